// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: FSM state encodings and stream framing sizes.
package prog_loader_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_HI = 4'd1;
    localparam logic [3:0] S_LEN_LO = 4'd2;
    localparam logic [3:0] S_DAT_HI = 4'd3;
    localparam logic [3:0] S_DAT_LO = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
    localparam logic [3:0] S_CHK    = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    localparam int LEN_BYTES = 2;
    localparam int CHK_BYTES = 1;

    // Total bytes on the wire for a load of the given word count.
    function automatic int stream_bytes(input logic [15:0] count);
        return LEN_BYTES + 2 * int'(count) + CHK_BYTES;
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Assembles big-endian byte pairs into a 16-bit word and keeps a running XOR of every accepted byte.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        accept,
    input  logic        sel_hi,
    input  logic        clear,
    output logic [15:0] word,
    output logic [7:0]  xsum
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= '0;
            xsum <= '0;
        end else if (accept) begin
            if (sel_hi) word[15:8] <= data;
            else        word[7:0]  <= data;
            xsum <= xsum ^ data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: count, big-endian words, XOR checksum; writes RAM from address 0 and holds the CPU until a good load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    logic [3:0]        state;
    logic [15:0]       count;
    logic [15:0]       len_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;
    logic [15:0]       word;
    logic [7:0]        xsum;
    logic [15:0]       next_words;
    logic              take;
    logic              rest;
    logic              clear;

    assign rest     = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DAT_HI)
                   || (state == S_DAT_LO) || (state == S_CHK);
    assign take     = in_valid && in_ready;
    assign clear    = start && rest;
    assign busy     = !rest;
    assign cpu_hold = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign mem_wren = (state == S_WRITE);

    // NOTE: the port shows the live index/word during WRITE and the captured copy afterwards, so the strobe lands the cycle after DAT_LO.
    assign mem_addr   = mem_wren ? idx  : addr_q;
    assign mem_data   = mem_wren ? word : data_q;
    assign next_words = words_loaded + 16'd1;
    assign len_next   = {count[15:8], in_data};

    loader_word_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .data   (in_data),
        .accept (take && ((state == S_DAT_HI) || (state == S_DAT_LO))),
        .sel_hi (state == S_DAT_HI),
        .clear  (clear),
        .word   (word),
        .xsum   (xsum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            idx          <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        count        <= '0;
                        idx          <= '0;
                        words_loaded <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (take) begin
                        count[15:8] <= in_data;
                        state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (take) begin
                        count[7:0] <= in_data;
                        if (32'(len_next) > 32'(DEPTH)) state <= S_ERR;
                        else if (len_next == 16'd0)     state <= S_CHK;
                        else                            state <= S_DAT_HI;
                    end
                end
                S_DAT_HI: if (take) state <= S_DAT_LO;
                S_DAT_LO: if (take) state <= S_WRITE;
                S_WRITE: begin
                    idx          <= idx + ADDR_W'(1);
                    words_loaded <= next_words;
                    addr_q       <= idx;
                    data_q       <= word;
                    state        <= (next_words == count) ? S_CHK : S_DAT_HI;
                end
                S_CHK: begin
                    if (take) state <= (in_data == xsum) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads with a write scoreboard, plus reset/start corner sequences.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [0:9][7:0] b;
        int              n;
        int              gap;
        bit              exp_done;
        bit              exp_err;
        int              exp_words;
    } vec_t;

    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;
    logic wren_prev = 1'b0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: sampled 1 ns after the falling edge so bench-driven inputs have settled.
    always @(negedge clk) begin
        #1;
        if (busy && in_valid && !in_ready) stalls++;
        if (mem_wren) begin
            check("wren_single_cycle", 32'(wren_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e.addr));
                check("write_data", 32'(mem_data), 32'(e.data));
            end
        end
        wren_prev = mem_wren;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("ready_timeout", 32'(t), 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int id);
        logic [15:0] cnt;
        cnt = {v.b[0], v.b[1]};
        pulse_start();
        check($sformatf("v%0d_start_busy", id), 32'(busy), 32'd1);
        check($sformatf("v%0d_start_words", id), 32'(words_loaded), 32'd0);
        check($sformatf("v%0d_start_flags", id), {30'd0, done, err}, 32'd0);
        if (32'(cnt) <= 32'(DEPTH)) begin
            for (int w = 0; w < int'(cnt) && 3 + 2 * w < v.n; w++)
                exp_q.push_back('{addr: 16'(w), data: {v.b[2 + 2 * w], v.b[3 + 2 * w]}});
        end
        stalls = 0;
        for (int i = 0; i < v.n; i++) send_byte(v.b[i], v.gap);
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_done", id), 32'(done), 32'(v.exp_done));
        check($sformatf("v%0d_err", id), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_words", id), 32'(words_loaded), 32'(v.exp_words));
        check($sformatf("v%0d_cpu_hold", id), 32'(cpu_hold), 32'(!v.exp_done));
        check($sformatf("v%0d_busy", id), 32'(busy), 32'd0);
        check($sformatf("v%0d_in_ready", id), 32'(in_ready), 32'd0);
        check($sformatf("v%0d_writes_left", id), 32'(exp_q.size()), 32'd0);
        check($sformatf("v%0d_stalls", id), 32'(stalls), 32'((v.gap == 0) ? v.exp_words : 0));
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
                    n: 7, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[1] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00},
                    n: 7, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 2};
        vecs[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 0};
        vecs[3] = '{b: {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00},
                    n: 7, gap: 5, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
        vecs[4] = '{b: {8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 2, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[5] = '{b: {8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00},
                    n: 9, gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_words: 3};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_wren", 32'(mem_wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("stream_len_2w", 32'(stream_bytes(16'd2)), 32'd7);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        // Reset after the first word lands; a start pulse while busy must not restart.
        pulse_start();
        exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        check("mid_words", 32'(words_loaded), 32'd1);
        pulse_start();
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_words", 32'(words_loaded), 32'd1);
        check("busy_start_ready", 32'(in_ready), 32'd1);
        check("first_write_seen", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_wins_idle", 32'(busy), 32'd0);

        apply_vec(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the SIMPLE processor's instruction/data RAM; the processor only reads program words from that RAM, and this block fills it.
- Accepts a byte stream over a valid/ready handshake: 16-bit word count, N big-endian 16-bit words, then a 1-byte XOR checksum.
- Writes each assembled word to consecutive RAM addresses from 0 and holds the CPU (cpu_hold) until the load completes.
- Sits beside the processor top; its RAM port is muxed ahead of the processor's address/data/wren.

Parameters:
- ADDR_W, 16, RAM address width.
- DEPTH, 4096, number of writable words; a count above DEPTH is an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins a load when idle, done or err
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- mem_addr  out  ADDR_W  RAM write address
- mem_data  out  16  RAM write data
- mem_wren  out  1  RAM write strobe, one cycle per word
- cpu_hold  out  1  processor must stay halted
- busy  out  1  load in progress
- done  out  1  sticky: load finished, checksum good
- err  out  1  sticky: checksum mismatch or count > DEPTH
- words_loaded  out  16  words written so far

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE. in_ready, mem_wren, busy, done and err are 0. mem_addr, mem_data and words_loaded are 0. cpu_hold is 1, so the CPU is held from power-up until the first good load.
- Byte transfer occurs only when in_valid && in_ready are high at a rising edge. in_data is ignored at all other times.
- FSM states: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR.
- IDLE, DONE, ERR: start moves to LEN_HI. On that move, clear done, err, words_loaded, the checksum accumulator and the address. start is ignored in all other states.
- LEN_HI, then LEN_LO: form count[15:8] and count[7:0].
- After LEN_LO:
  - count > DEPTH: go to ERR.
  - count == 0: go to CHK.
  - otherwise: go to DAT_HI.
- DAT_HI, then DAT_LO: form word[15:8] and word[7:0]. After DAT_LO, go to WRITE.
- WRITE lasts exactly one cycle:
  - mem_wren=1, mem_addr=current index, mem_data=word.
  - Next cycle: index+1 and words_loaded+1.
  - If words_loaded+1 == count, go to CHK; else go to DAT_HI.
- Latency: the DAT_LO byte is accepted at edge t; the write strobe is high in the cycle after edge t.
- CHK: one byte is accepted.
  - It equals the XOR of all payload bytes (count bytes excluded, zero-length payload gives 0x00): go to DONE and set done=1.
  - Otherwise: go to ERR and set err=1.
- in_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK. In all other states it is 0, including WRITE, which applies backpressure for one cycle per word.
- busy=1 in every state except IDLE, DONE and ERR.
- cpu_hold=1 in every state except DONE. A failed load keeps the CPU halted.
- mem_wren is 0 outside WRITE. mem_addr and mem_data hold their last values.
- Index wraps at 2^ADDR_W. This cannot occur while DEPTH ≤ 2^ADDR_W.
- in_valid may drop between bytes for any number of cycles; the FSM waits in its current state.
- rst mid-load: the next cycle is in reset state, and writes already made stay in RAM. If rst and start are high together, rst wins.
- A start pulse during busy has no effect on any output.

Decomposition:
- Shared package (prog_loader_pkg): state encoding constants (4-bit localparams for the 9 states), LEN_BYTES=2, CHK_BYTES=1.
- One sub-module, loader_word_asm: byte-pair assembly plus running XOR. Inputs: byte, accept strobe, hi/lo select, clear. Outputs: 16-bit word and 8-bit xor.
- The FSM, counters and memory port stay in prog_loader.

Test Plan:
- Reset, then start, then stream 00 02 | 12 34 | AB CD | 40 (0x12^0x34^0xAB^0xCD = 0x40) -> expect:
  - writes (0,0x1234) and (1,0xABCD), each a single-cycle mem_wren;
  - done=1, err=0, words_loaded=2, cpu_hold=0.
- Same stream with checksum 41 -> expect err=1, done=0, cpu_hold=1, and both words still written.
- Count 0: stream 00 00 | 00 -> expect done=1, no mem_wren ever, words_loaded=0.
- Count 0x1001 with DEPTH=4096 -> expect err=1 right after LEN_LO, no data bytes accepted, in_ready=0.
- Hold in_valid=1 for the whole stream -> in_ready=0 for exactly one cycle after each DAT_LO byte. Then insert 5-cycle in_valid gaps -> identical writes.
- Assert rst after the first word is written -> next cycle IDLE, cpu_hold=1, busy=0. A start pulse asserted while busy is ignored and causes no restart.
